// File: rtl/b11_stim_tx.sv
// Transmit end of the b11 strobe interface: buffers host words, commits each one with a one-cycle stbi low, then guards.
// Latency: word pushed at edge k is committed (stbi low) in the cycle after edge k+1 when the FSM is idle; period GAP+2.
// Backpressure: in_ready = !full (and low during reset); a held word waits for the next pop.
//
// Ports:
//   clock, reset (async, active-low)
//   in_data/in_valid/in_ready : host valid/ready word port
//   x_in/stbi                 : word and commit strobe to the b11 core
//   resp_expect               : pulses with the strobe when the committed word updates x_out
//   busy                      : FIFO non-empty or a strobe/guard in progress
//   sent_count                : words committed since reset, wraps

module b11_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // One extra pointer bit separates full from empty.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push_vld & ~full;
  assign do_pop   = pop & ~empty;
  // Head is read from storage, so a word written at an edge is only visible after it.
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

module b11_stim_tx #(
  parameter int DEPTH = 4,
  parameter int GAP   = 12,
  parameter int INIT  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [5:0] x_in,
  output logic       stbi,
  output logic       resp_expect,
  output logic       busy,
  output logic [7:0] sent_count
);
  localparam int CMAX = (GAP > INIT) ? GAP : INIT;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_STROBE, S_GUARD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [5:0]    x_nxt;
  logic          stbi_nxt;
  logic          resp_nxt;
  logic [7:0]    sent_nxt;
  logic          pop;
  logic [5:0]    head_dat;
  logic          full;
  logic          empty;
  logic          head_resp;

  b11_fifo #(.W(6), .DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_vld (in_valid),
    .push_dat (in_data),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (full),
    .empty    (empty)
  );

  // Held low while reset is asserted so the host cannot push into a FIFO being cleared.
  assign in_ready  = reset & ~full;
  assign busy      = ((state != S_IDLE) && (state != S_INIT)) | ~empty;
  // Words 27..62 are dropped by the core without touching x_out.
  assign head_resp = (head_dat == 6'd0) | (head_dat == 6'd63) | (head_dat <= 6'd26);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    x_nxt     = x_in;
    stbi_nxt  = 1'b1;
    resp_nxt  = 1'b0;
    sent_nxt  = sent_count;
    pop       = 1'b0;
    case (state)
      S_INIT: begin
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          x_nxt     = head_dat;
          stbi_nxt  = 1'b0;
          resp_nxt  = head_resp;
          sent_nxt  = sent_count + 8'd1;
          state_nxt = S_STROBE;
        end
      end
      S_STROBE: begin
        cnt_nxt   = CW'(GAP - 1);
        state_nxt = S_GUARD;
      end
      S_GUARD: begin
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_INIT;
      cnt         <= CW'(INIT - 1);
      x_in        <= '0;
      stbi        <= 1'b1;
      resp_expect <= 1'b0;
      sent_count  <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      x_in        <= x_nxt;
      stbi        <= stbi_nxt;
      resp_expect <= resp_nxt;
      sent_count  <= sent_nxt;
    end
  end
endmodule
